// File: rtl/quadrature_window_scheduler_if.sv
// rtl/quadrature_window_scheduler_if.sv - window result stream (SIN/COS differences, cycle span) with valid/ready.
interface quadrature_window_scheduler_if #(
  parameter int RESULT_WIDTH = 32,
  parameter int CYCLE_BITS   = 24
);
  logic signed [RESULT_WIDTH-1:0] out_sin;
  logic signed [RESULT_WIDTH-1:0] out_cos;
  logic        [CYCLE_BITS-1:0]   out_cycles;
  logic                           tvalid;
  logic                           tready;

  modport master (
    output out_sin,
    output out_cos,
    output out_cycles,
    output tvalid,
    input  tready
  );

  modport slave (
    input  out_sin,
    input  out_cos,
    input  out_cycles,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/quadrature_window_scheduler.sv
// rtl/quadrature_window_scheduler.sv - zero-crossing windowed differencing of quadrature accumulators.
// Optional cycle counter enabled by defining QUAD_SCHED_CYCLE_COUNT_EN; otherwise out_cycles is tied to 0.
module quadrature_window_scheduler #(
  parameter int RESULT_WIDTH = 32,
  parameter int PERIOD_BITS  = 8,
  parameter int CYCLE_BITS   = 24
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_ce,
  input  logic                           i_enable,
  input  logic [PERIOD_BITS-1:0]         i_periods,
  input  logic                           i_zero_cross,
  input  logic signed [RESULT_WIDTH-1:0] i_sin_acc,
  input  logic signed [RESULT_WIDTH-1:0] i_cos_acc,
  output logic                           o_busy,
  output logic                           o_overrun,
  input  logic                           i_clear_overrun,
  quadrature_window_scheduler_if.master  m_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]                     r_state;
  logic signed [RESULT_WIDTH-1:0] r_base_sin;
  logic signed [RESULT_WIDTH-1:0] r_base_cos;
  logic [PERIOD_BITS-1:0]         r_len;
  logic [PERIOD_BITS-1:0]         r_xcnt;
  logic signed [RESULT_WIDTH-1:0] r_out_sin;
  logic signed [RESULT_WIDTH-1:0] r_out_cos;
  logic [CYCLE_BITS-1:0]          r_out_cycles;
  logic                           r_valid;
  logic                           r_overrun;

  logic                   w_event;
  logic [PERIOD_BITS-1:0] w_len;
  logic [PERIOD_BITS-1:0] w_xcnt_nxt;
  logic                   w_complete;
  logic                   w_load;
  logic [CYCLE_BITS-1:0]  w_cyc_done;

  assign w_event    = i_ce & i_zero_cross;
  assign w_len      = (i_periods == '0) ? PERIOD_BITS'(1) : i_periods;
  assign w_xcnt_nxt = r_xcnt + 1'b1;
  assign w_complete = (r_state == S_RUN) & i_enable & w_event & (w_xcnt_nxt == r_len);
  // A result is accepted into the holding register only if it is empty or being drained this cycle.
  assign w_load     = w_complete & (~r_valid | m_res.tready);

`ifdef QUAD_SCHED_CYCLE_COUNT_EN
  logic [CYCLE_BITS-1:0] r_cyc;
  logic [CYCLE_BITS-1:0] w_cyc_inc;

  assign w_cyc_inc  = (&r_cyc) ? r_cyc : r_cyc + 1'b1;
  assign w_cyc_done = w_cyc_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc <= '0;
    end else if (r_state == S_ARM) begin
      if (i_enable && w_event) r_cyc <= '0;
    end else if (r_state == S_RUN && i_enable && i_ce) begin
      r_cyc <= w_complete ? '0 : w_cyc_inc;
    end
  end
`else
  assign w_cyc_done = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_base_sin <= '0;
      r_base_cos <= '0;
      r_len      <= '0;
      r_xcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ce && i_enable) r_state <= S_ARM;
        end
        S_ARM: begin
          if (!i_enable) begin
            r_state <= S_IDLE;
          end else if (w_event) begin
            r_base_sin <= i_sin_acc;
            r_base_cos <= i_cos_acc;
            r_len      <= w_len;
            r_xcnt     <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (!i_enable) begin
            r_state <= S_IDLE;
          end else if (w_complete) begin
            // Completing crossing doubles as the next window's baseline, so no crossing is lost.
            r_base_sin <= i_sin_acc;
            r_base_cos <= i_cos_acc;
            r_len      <= w_len;
            r_xcnt     <= '0;
          end else if (w_event) begin
            r_xcnt <= w_xcnt_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_sin    <= '0;
      r_out_cos    <= '0;
      r_out_cycles <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_sin    <= i_sin_acc - r_base_sin;
        r_out_cos    <= i_cos_acc - r_base_cos;
        r_out_cycles <= w_cyc_done;
        r_valid      <= 1'b1;
      end else if (r_valid && m_res.tready) begin
        r_valid <= 1'b0;
      end

      if (w_complete && !w_load) begin
        r_overrun <= 1'b1;
      end else if (i_clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign m_res.out_sin    = r_out_sin;
  assign m_res.out_cos    = r_out_cos;
  assign m_res.out_cycles = r_out_cycles;
  assign m_res.tvalid     = r_valid;
  assign o_busy           = (r_state == S_ARM) || (r_state == S_RUN);
  assign o_overrun        = r_overrun;

endmodule

// File: doc/quadrature_window_scheduler.md
# quadrature_window_scheduler

Sequences readout of the free-running quadrature mul-acc accumulators: captures SIN/COS accumulator snapshots on ADC zero-crossing strobes, forms per-window differences over a programmable number of signal periods, and hands each result downstream over a valid/ready handshake. Sits between the quadrature mul-acc datapath and the phase/amplitude consumer, replacing ad-hoc software subtraction of accumulator samples.

## Interface
- RESULT_WIDTH, 32, width of accumulator inputs and difference outputs
- PERIOD_BITS, 8, width of the PERIODS window-length setting
- CYCLE_BITS, 24, width of the window cycle counter

- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable shared with the mul-acc pipeline
- ENABLE  in  1  1 = run windows, 0 = stop and discard partial window
- PERIODS  in  PERIOD_BITS  zero crossings per window; 0 treated as 1
- ZERO_CROSS  in  1  zero-crossing strobe from the mul-acc datapath
- SIN_ACC  in  RESULT_WIDTH signed  running ADC*SIN accumulator
- COS_ACC  in  RESULT_WIDTH signed  running ADC*COS accumulator
- OUT_SIN  out  RESULT_WIDTH signed  SIN accumulator difference over window
- OUT_COS  out  RESULT_WIDTH signed  COS accumulator difference over window
- OUT_CYCLES  out  CYCLE_BITS  CE-qualified cycles spanned by window
- OUT_VALID  out  1  result held and valid
- OUT_READY  in  1  consumer accepts result
- BUSY  out  1  state is ARM or RUN
- OVERRUN  out  1  sticky: a completed window was dropped
- CLEAR_OVERRUN  in  1  clears OVERRUN

## Operation
- Event = CE & ZERO_CROSS. Counters and state advance only when CE = 1; handshake (OUT_VALID/OUT_READY) and CLEAR_OVERRUN act every cycle regardless of CE.
- States: IDLE, ARM, RUN.
  - IDLE: ENABLE = 1 -> ARM.
  - ARM: on event, capture baseline SIN_ACC/COS_ACC, load window length from PERIODS (0 -> 1), clear crossing and cycle counters -> RUN.
  - RUN: cycle counter +1 per CE cycle, saturating at all-ones. On event, crossing counter +1; when it reaches window length: result = current accumulator minus baseline, OUT_CYCLES = cycle count + 1 (saturated), baseline <= current accumulators, reload PERIODS, clear counters, stay RUN (back-to-back windows, no lost crossing).
  - ENABLE = 0 in ARM or RUN -> IDLE next cycle; partial window discarded, no result produced. Pending OUT_VALID unaffected.
- Arithmetic: differences are modulo 2^RESULT_WIDTH (two's-complement wrap); accumulator wrap between snapshots yields correct difference.
- Output register: on window completion, if OUT_VALID = 0 or OUT_READY = 1 in the same cycle, load new result and assert OUT_VALID. Otherwise keep old result, drop new one, set OVERRUN.
- OUT_VALID clears on cycle with OUT_VALID & OUT_READY and no simultaneous load.
- OVERRUN: set wins over CLEAR_OVERRUN in same cycle.

## Timing
- Reset values: state IDLE; OUT_SIN, OUT_COS, OUT_CYCLES = 0; OUT_VALID = 0; BUSY = 0; OVERRUN = 0; internal baseline/counters = 0.
- Result latency: OUT_VALID rises on the clock edge sampling the completing event; data visible the cycle after that event.
- BUSY asserts the cycle after ENABLE sampled 1 in IDLE.
- Outputs registered; no combinational path from OUT_READY to OUT_VALID.
- Reset assertion mid-window: all state cleared immediately (asynchronous); release synchronous to CLK.

## Configuration
- QUAD_SCHED_CYCLE_COUNT_EN defined: cycle counter implemented, OUT_CYCLES as above.
- Not defined: cycle counter removed; OUT_CYCLES constant 0; all other behaviour identical.

## Test plan
- Reset, ENABLE = 1, PERIODS = 2, CE = 1, events at cycles 10, 20, 30 with SIN_ACC = 100, 400, 1000, COS_ACC = -50, -20, 70 -> one result: OUT_SIN = 900, OUT_COS = 120, OUT_CYCLES = 20, OUT_VALID one cycle after the cycle-30 event.
- Wrap: PERIODS = 1, SIN_ACC 0x7FFFFFF0 then 0x80000010 -> OUT_SIN = 0x20.
- Overrun: PERIODS = 1, OUT_READY = 0, three events -> first result held, OVERRUN = 1; CLEAR_OVERRUN pulse -> OVERRUN = 0; event coincident with OUT_READY = 1 -> new result loaded, OVERRUN stays 0.
- ENABLE dropped after one of PERIODS = 4 crossings -> IDLE, no OUT_VALID; re-enable -> ARM recaptures baseline, next result spans 4 fresh crossings.
- CE = 0 with ZERO_CROSS = 1 for 5 cycles mid-window -> no count change, OUT_CYCLES excludes those cycles; OUT_READY still clears OUT_VALID.
- PERIODS = 0 -> behaves as 1: result every event; RESET pulled low mid-RUN -> all outputs 0 immediately.
